// File: rtl/event_accumulator_flag_if.sv
// event_accumulator_flag_if
// Purpose: groups the event/enable/ack inputs and the flag/count/overflow
//          status outputs of event_accumulator_flag into one bundle.
// Signals:
//   event_in  : asynchronous event line, each rising edge is one event
//   enable    : counting enable (clk domain)
//   ack_in    : clear request level (clk domain), acts on its rising edge
//   flag_out  : sticky threshold-reached flag, feeds the PIO in_port
//   count_out : registered event count
//   overflow  : sticky, an event arrived while the count was all-ones
// Modports: master drives the inputs and observes the status,
//           slave is the accumulator side.
interface event_accumulator_flag_if #(
  parameter int COUNT_W = 16
);
  logic               event_in;
  logic               enable;
  logic               ack_in;
  logic               flag_out;
  logic [COUNT_W-1:0] count_out;
  logic               overflow;

  modport master (
    output event_in,
    output enable,
    output ack_in,
    input  flag_out,
    input  count_out,
    input  overflow
  );

  modport slave (
    input  event_in,
    input  enable,
    input  ack_in,
    output flag_out,
    output count_out,
    output overflow
  );
endinterface

// File: rtl/event_accumulator_flag.sv
// event_accumulator_flag
// Purpose: synchronises an asynchronous event line, counts its rising edges
//          and raises a sticky flag once THRESHOLD events have been seen.
//          Software clears flag, count and overflow with a rising edge on ack_in.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset (released synchronously inside)
//   bus     : event_accumulator_flag_if slave modport
//             (event_in, enable, ack_in -> flag_out, count_out, overflow)
// Parameters:
//   SYNC_STAGES : synchroniser depth on event_in, 2..4
//   COUNT_W     : event counter width
//   THRESHOLD   : count that raises flag_out, 1..2^COUNT_W-1
module event_accumulator_flag #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 16,
  parameter int THRESHOLD   = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  event_accumulator_flag_if.slave bus
);

  localparam logic [COUNT_W-1:0] TH_VAL    = COUNT_W'(THRESHOLD);
  localparam logic [COUNT_W-1:0] ALL_ONES  = '1;
  localparam bit                 TH_IS_ONE = (THRESHOLD == 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Elaboration-time parameter sanity checks.
  if ((THRESHOLD < 1) || (longint'(THRESHOLD) > ((longint'(1) << COUNT_W) - 1))) begin : g_badThreshold
    initial $error("event_accumulator_flag: THRESHOLD=%0d illegal for COUNT_W=%0d", THRESHOLD, COUNT_W);
  end
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_badSync
    initial $error("event_accumulator_flag: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
  end

  logic [1:0]             r_rstSync;
  logic                   w_rstN;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_evPrev;
  logic                   r_ack;
  state_t                 r_state;
  logic [COUNT_W-1:0]     r_count;
  logic                   r_flag;
  logic                   r_ovf;

  logic                   w_evPulse;
  logic                   w_ev;
  logic                   w_ackPulse;
  logic [COUNT_W-1:0]     w_countInc;

  // Reset asserts asynchronously but releases on a clock edge, so no flop
  // leaves reset in the middle of a cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rstSync <= 2'b00;
    end else begin
      r_rstSync <= {r_rstSync[0], 1'b1};
    end
  end

  assign w_rstN = r_rstSync[1];

  // Event synchroniser plus edge register. These keep running with enable
  // low so that no stale edge is seen when enable rises again.
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_sync   <= '0;
      r_evPrev <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.event_in};
      r_evPrev <= r_sync[SYNC_STAGES-1];
      r_ack    <= bus.ack_in;
    end
  end

  assign w_evPulse  = r_sync[SYNC_STAGES-1] & ~r_evPrev;
  assign w_ev       = w_evPulse & bus.enable;
  assign w_ackPulse = bus.ack_in & ~r_ack;
  assign w_countInc = r_count + 1'b1;

  // Main FSM. An ack outside IDLE wins over the normal update, but an event
  // on the same cycle is still counted as the first event after the clear.
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_state <= IDLE;
      r_count <= '0;
      r_flag  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_ackPulse && (r_state != IDLE)) begin
      r_ovf <= 1'b0;
      if (w_ev) begin
        r_count <= {{(COUNT_W-1){1'b0}}, 1'b1};
        r_flag  <= TH_IS_ONE;
        r_state <= TH_IS_ONE ? FULL : ACCUM;
      end else begin
        r_count <= '0;
        r_flag  <= 1'b0;
        r_state <= IDLE;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ev) begin
            r_count <= {{(COUNT_W-1){1'b0}}, 1'b1};
            r_flag  <= TH_IS_ONE;
            r_state <= TH_IS_ONE ? FULL : ACCUM;
          end
        end
        ACCUM: begin
          if (w_ev) begin
            r_count <= w_countInc;
            if (w_countInc == TH_VAL) begin
              r_flag  <= 1'b1;
              r_state <= FULL;
            end
          end
        end
        FULL: begin
          r_flag <= 1'b1;
          if (w_ev) begin
            if (r_count == ALL_ONES) begin
              r_ovf <= 1'b1;
            end else begin
              r_count <= w_countInc;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
          r_flag  <= 1'b0;
          r_ovf   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.flag_out  = r_flag;
  assign bus.count_out = r_count;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_event_accumulator_flag.sv
// tb_event_accumulator_flag
// Purpose: self-checking bench for event_accumulator_flag. Two instances:
//          A with defaults (COUNT_W=16, THRESHOLD=8), B with COUNT_W=4 for
//          saturation. A behavioural model predicts every output each cycle.
module tb_event_accumulator_flag;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int nCompared = 0;
  int nMismatched = 0;

  event_accumulator_flag_if #(.COUNT_W(16)) busA ();
  event_accumulator_flag_if #(.COUNT_W(4))  busB ();

  event_accumulator_flag #(.SYNC_STAGES(SYNC), .COUNT_W(16), .THRESHOLD(8)) dutA (
    .clk(clk), .reset_n(reset_n), .bus(busA)
  );
  event_accumulator_flag #(.SYNC_STAGES(SYNC), .COUNT_W(4), .THRESHOLD(8)) dutB (
    .clk(clk), .reset_n(reset_n), .bus(busB)
  );

  always #5 clk = ~clk;

  // Model state per instance: index 0 = A, 1 = B.
  int thr[2]    = '{8, 8};
  int maxCnt[2] = '{65535, 15};
  int mCount[2];
  int mFlag[2];
  int mOvf[2];
  int lastSample[2];
  int ackPrev[2];
  int edgeHist[2][SYNC];
  int holdCnt;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void modelClear();
    for (int d = 0; d < 2; d++) begin
      mCount[d] = 0;
      mFlag[d] = 0;
      mOvf[d] = 0;
      lastSample[d] = 0;
      ackPrev[d] = 0;
      for (int k = 0; k < SYNC; k++) edgeHist[d][k] = 0;
    end
  endfunction

  // One clock edge of the model: an edge sampled on event_in takes effect
  // SYNC edges later; ack acts on the edge it is first seen high.
  function automatic void modelStep(input int d, input int evIn, input int en, input int ack);
    int e, eff, ev, ackP;
    e = (evIn != 0 && lastSample[d] == 0) ? 1 : 0;
    lastSample[d] = evIn;
    eff = edgeHist[d][SYNC-1];
    for (int k = SYNC - 1; k > 0; k--) edgeHist[d][k] = edgeHist[d][k-1];
    edgeHist[d][0] = e;
    ev = (eff != 0 && en != 0) ? 1 : 0;
    ackP = (ack != 0 && ackPrev[d] == 0) ? 1 : 0;
    ackPrev[d] = ack;
    if (ackP != 0 && mCount[d] != 0) begin
      mOvf[d] = 0;
      mCount[d] = ev;
      mFlag[d] = (ev != 0 && thr[d] == 1) ? 1 : 0;
    end else if (ev != 0) begin
      if (mCount[d] == maxCnt[d]) mOvf[d] = 1;
      else mCount[d] = mCount[d] + 1;
      if (mCount[d] >= thr[d]) mFlag[d] = 1;
    end
  endfunction

  // Model update; the DUT releases reset on the second edge after reset_n rises.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      modelClear();
      holdCnt = 2;
    end else if (holdCnt > 0) begin
      holdCnt--;
      modelClear();
    end else begin
      modelStep(0, int'(busA.event_in), int'(busA.enable), int'(busA.ack_in));
      modelStep(1, int'(busB.event_in), int'(busB.enable), int'(busB.ack_in));
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    checkOutput("A.count", int'(busA.count_out), mCount[0]);
    checkOutput("A.flag",  int'(busA.flag_out),  mFlag[0]);
    checkOutput("A.ovf",   int'(busA.overflow),  mOvf[0]);
    checkOutput("B.count", int'(busB.count_out), mCount[1]);
    checkOutput("B.flag",  int'(busB.flag_out),  mFlag[1]);
    checkOutput("B.ovf",   int'(busB.overflow),  mOvf[1]);
  end

  // Produces n well-formed events (3 clk high, 3 clk low) on the selected instance.
  task automatic applyStimulus(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel == 0) busA.event_in = 1'b1; else busB.event_in = 1'b1;
      repeat (3) @(negedge clk);
      if (sel == 0) busA.event_in = 1'b0; else busB.event_in = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  // Raises ack for one edge, then checks the cleared state.
  task automatic pulseAck(input int sel, input string name);
    @(negedge clk);
    if (sel == 0) busA.ack_in = 1'b1; else busB.ack_in = 1'b1;
    @(negedge clk);
    if (sel == 0) begin
      checkOutput({name, ".count"}, int'(busA.count_out), 0);
      checkOutput({name, ".flag"},  int'(busA.flag_out),  0);
      checkOutput({name, ".ovf"},   int'(busA.overflow),  0);
      busA.ack_in = 1'b0;
    end else begin
      checkOutput({name, ".count"}, int'(busB.count_out), 0);
      checkOutput({name, ".flag"},  int'(busB.flag_out),  0);
      checkOutput({name, ".ovf"},   int'(busB.overflow),  0);
      busB.ack_in = 1'b0;
    end
    @(negedge clk);
  endtask

  // Directed test sequence with hand-computed expectations.
  initial begin
    busA.event_in = 1'b0; busA.enable = 1'b1; busA.ack_in = 1'b0;
    busB.event_in = 1'b0; busB.enable = 1'b1; busB.ack_in = 1'b0;

    // T1: reset held while event_in toggles.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      busA.event_in = ~busA.event_in;
    end
    busA.event_in = 1'b0;
    @(negedge clk);
    checkOutput("T1.count", int'(busA.count_out), 0);
    checkOutput("T1.flag",  int'(busA.flag_out),  0);
    checkOutput("T1.ovf",   int'(busA.overflow),  0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // T2: seven events, then the eighth with exact flag timing.
    applyStimulus(0, 7);
    checkOutput("T2.count7", int'(busA.count_out), 7);
    checkOutput("T2.flag7",  int'(busA.flag_out),  0);
    @(negedge clk);
    busA.event_in = 1'b1;
    @(negedge clk);
    checkOutput("T2.flagN",   int'(busA.flag_out), 0);
    @(negedge clk);
    checkOutput("T2.flagN1",  int'(busA.flag_out), 0);
    checkOutput("T2.countN1", int'(busA.count_out), 7);
    @(negedge clk);
    checkOutput("T2.flagN2",  int'(busA.flag_out), 1);
    checkOutput("T2.countN2", int'(busA.count_out), 8);
    @(negedge clk);
    busA.event_in = 1'b0;
    repeat (3) @(negedge clk);

    // T3: three more events, then clear.
    applyStimulus(0, 3);
    checkOutput("T3.count", int'(busA.count_out), 11);
    checkOutput("T3.flag",  int'(busA.flag_out),  1);
    pulseAck(0, "T3.ack");

    // T4: reach FULL, then ack and event land on the same edge.
    applyStimulus(0, 8);
    checkOutput("T4.flagFull", int'(busA.flag_out), 1);
    @(negedge clk);
    busA.event_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    busA.ack_in = 1'b1;
    @(negedge clk);
    checkOutput("T4.count1", int'(busA.count_out), 1);
    checkOutput("T4.flag0",  int'(busA.flag_out),  0);
    busA.ack_in = 1'b0;
    @(negedge clk);
    busA.event_in = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(0, 6);
    checkOutput("T4.count7", int'(busA.count_out), 7);
    checkOutput("T4.flag7",  int'(busA.flag_out),  0);
    applyStimulus(0, 1);
    checkOutput("T4.count8", int'(busA.count_out), 8);
    checkOutput("T4.flag8",  int'(busA.flag_out),  1);

    // T5: saturation on the 4-bit instance.
    applyStimulus(1, 20);
    checkOutput("T5.count", int'(busB.count_out), 15);
    checkOutput("T5.ovf",   int'(busB.overflow),  1);
    checkOutput("T5.flag",  int'(busB.flag_out),  1);
    pulseAck(1, "T5.ack");

    // T6: enable gating, then asynchronous reset between edges.
    pulseAck(0, "T6.ack");
    applyStimulus(0, 5);
    checkOutput("T6.count5", int'(busA.count_out), 5);
    busA.enable = 1'b0;
    applyStimulus(0, 5);
    checkOutput("T6.held", int'(busA.count_out), 5);
    busA.enable = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("T6.noStale", int'(busA.count_out), 5);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("T6.asyncCount", int'(busA.count_out), 0);
    checkOutput("T6.asyncFlag",  int'(busA.flag_out),  0);
    checkOutput("T6.asyncOvf",   int'(busA.overflow),  0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
